// File: rtl/cpu_pkg.sv
// Shared types for the PC controller: decoded ops, FSM states, trap causes.
// Imported by pc_target_calc and pc_ctrl.
package cpu_pkg;

    typedef enum logic [5:0] {
        CU_LUI   = 6'd0,
        CU_AUIPC = 6'd1,
        CU_JAL   = 6'd2,
        CU_JALR  = 6'd3,
        CU_BEQ   = 6'd4,
        CU_BNE   = 6'd5,
        CU_BLT   = 6'd6,
        CU_BGE   = 6'd7,
        CU_BLTU  = 6'd8,
        CU_BGEU  = 6'd9,
        CU_LOAD  = 6'd10,
        CU_STORE = 6'd11,
        CU_ALU   = 6'd12,
        CU_ALUI  = 6'd13,
        CU_ERROR = 6'd14
    } cuOPType;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_EXT      = 2'd2;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational jump/branch resolution: taken flag, target, misalignment.
// Ports: op_i, pc_i, rs1_i, imm_i, cmp_*_i in; taken_o, target_o, misalign_o out.
module pc_target_calc
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMM_SCALED = 1
) (
    input  cuOPType           op_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              cmp_eq_i,
    input  logic              cmp_lt_i,
    input  logic              cmp_ltu_i,
    output logic              taken_o,
    output logic [XLEN-1:0]   target_o,
    output logic              misalign_o
);

    logic [XLEN-1:0] off;
    logic [XLEN-1:0] rel_tgt;
    logic [XLEN-1:0] jalr_sum;

    assign off      = (IMM_SCALED != 0) ? imm_i : (imm_i << 1);
    assign rel_tgt  = pc_i + off;
    assign jalr_sum = rs1_i + imm_i;

    always_comb begin
        taken_o  = 1'b0;
        target_o = rel_tgt;
        unique case (op_i)
            CU_JAL:  taken_o = 1'b1;
            CU_JALR: begin
                taken_o  = 1'b1;
                target_o = {jalr_sum[XLEN-1:1], 1'b0};
            end
            CU_BEQ:  taken_o = cmp_eq_i;
            CU_BNE:  taken_o = !cmp_eq_i;
            CU_BLT:  taken_o = cmp_lt_i;
            CU_BGE:  taken_o = !cmp_lt_i;
            CU_BLTU: taken_o = cmp_ltu_i;
            CU_BGEU: taken_o = !cmp_ltu_i;
            default: taken_o = 1'b0;
        endcase
    end

    // Only bit 1 matters: bit 0 of JALR is forced low, 16-bit grain is not a trap
    assign misalign_o = taken_o & target_o[1];

endmodule

// File: rtl/pc_ctrl.sv
// PC controller: BOOT/RUN/TRAP FSM, PC, EPC/cause capture, optional counters.
// Ports: clk, nRST, cuOP, rs1Read, imm_i, cmp_*, iready, trap_i, trap_ack in;
// PCaddr, pc_plus4, fetch_req, trap_o, epc_o, cause_o, taken_cnt, retire_cnt out.
// Define PC_PERF_EN to build the taken/retire counters.
module pc_ctrl
    import cpu_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h100),
    parameter int              IMM_SCALED = 1
) (
    input  logic             clk,
    input  logic             nRST,
    input  cuOPType          cuOP,
    input  logic [XLEN-1:0]  rs1Read,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    input  logic             cmp_ltu,
    input  logic             iready,
    input  logic             trap_i,
    input  logic             trap_ack,
    output logic [XLEN-1:0]  PCaddr,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             fetch_req,
    output logic             trap_o,
    output logic [XLEN-1:0]  epc_o,
    output logic [1:0]       cause_o,
    output logic [31:0]      taken_cnt,
    output logic [31:0]      retire_cnt
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [1:0]      cause_q, cause_d;
    logic            trap_q, trap_d;
    logic            taken;
    logic            misalign;
    logic [XLEN-1:0] target;

    pc_target_calc #(
        .XLEN       (XLEN),
        .IMM_SCALED (IMM_SCALED)
    ) u_tgt (
        .op_i       (cuOP),
        .pc_i       (pc_q),
        .rs1_i      (rs1Read),
        .imm_i      (imm_i),
        .cmp_eq_i   (cmp_eq),
        .cmp_lt_i   (cmp_lt),
        .cmp_ltu_i  (cmp_ltu),
        .taken_o    (taken),
        .target_o   (target),
        .misalign_o (misalign)
    );

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        trap_d  = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // External request wins over misalignment and retire
                if (trap_i || (iready && misalign)) begin
                    state_d = TRAP;
                    pc_d    = TRAP_VEC;
                    epc_d   = pc_q;
                    cause_d = trap_i ? CAUSE_EXT : CAUSE_MISALIGN;
                    trap_d  = 1'b1;
                end else if (iready) begin
                    pc_d = taken ? target : pc_plus4;
                end
            end
            TRAP: begin
                pc_d = TRAP_VEC;
                if (trap_ack) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            cause_q <= CAUSE_NONE;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            trap_q  <= trap_d;
        end
    end

    assign PCaddr    = pc_q;
    assign fetch_req = (state_q == RUN);
    assign trap_o    = trap_q;
    assign epc_o     = epc_q;
    assign cause_o   = cause_q;

`ifdef PC_PERF_EN
    logic        retire;
    logic [31:0] taken_q, retire_q;

    assign retire = (state_q == RUN) && iready && !trap_i && !misalign;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            taken_q  <= '0;
            retire_q <= '0;
        end else if (retire) begin
            retire_q <= retire_q + 32'd1;
            if (taken) taken_q <= taken_q + 32'd1;
        end
    end

    assign taken_cnt  = taken_q;
    assign retire_cnt = retire_q;
`else
    assign taken_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: vector table with scoreboard queue,
// plus directed trap, wrap and reset sequences.
module tb_pc_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        nRST;
    cuOPType     cuOP;
    logic [31:0] rs1Read, imm_i;
    logic        cmp_eq, cmp_lt, cmp_ltu;
    logic        iready, trap_i, trap_ack;
    logic [31:0] PCaddr, pc_plus4, epc_o;
    logic        fetch_req, trap_o;
    logic [1:0]  cause_o;
    logic [31:0] taken_cnt, retire_cnt;

    pc_ctrl dut (
        .clk        (clk),
        .nRST       (nRST),
        .cuOP       (cuOP),
        .rs1Read    (rs1Read),
        .imm_i      (imm_i),
        .cmp_eq     (cmp_eq),
        .cmp_lt     (cmp_lt),
        .cmp_ltu    (cmp_ltu),
        .iready     (iready),
        .trap_i     (trap_i),
        .trap_ack   (trap_ack),
        .PCaddr     (PCaddr),
        .pc_plus4   (pc_plus4),
        .fetch_req  (fetch_req),
        .trap_o     (trap_o),
        .epc_o      (epc_o),
        .cause_o    (cause_o),
        .taken_cnt  (taken_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        cuOPType     op;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [2:0]  cmp;
        logic [2:0]  ctl;
        logic [31:0] pc;
        logic        fr;
        logic        tro;
        logic        ret;
        logic        tk;
    } vec_t;

    vec_t        sb[$];
    vec_t        tbl[$];
    int          total = 0;
    int          passed = 0;
    int          m_ret = 0;
    int          m_tk = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input cuOPType op,
        input logic [31:0] rs1, input logic [31:0] imm,
        input logic [2:0] cmp, input logic [2:0] ctl,
        input logic [31:0] pc, input logic fr, input logic tro,
        input logic ret, input logic tk);
        vec_t v;
        v.nm = nm; v.op = op; v.rs1 = rs1; v.imm = imm;
        v.cmp = cmp; v.ctl = ctl; v.pc = pc; v.fr = fr;
        v.tro = tro; v.ret = ret; v.tk = tk;
        return v;
    endfunction

    // cmp = {eq,lt,ltu}; ctl = {iready,trap_i,trap_ack}
    task automatic apply(input vec_t v);
        vec_t e;
        cuOP = v.op; rs1Read = v.rs1; imm_i = v.imm;
        {cmp_eq, cmp_lt, cmp_ltu} = v.cmp;
        {iready, trap_i, trap_ack} = v.ctl;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.ret) m_ret++;
        if (e.ret && e.tk) m_tk++;
        chk({e.nm, ".pc"}, PCaddr, e.pc);
        chk({e.nm, ".fr"}, 32'(fetch_req), 32'(e.fr));
        chk({e.nm, ".trap"}, 32'(trap_o), 32'(e.tro));
`ifdef PC_PERF_EN
        chk({e.nm, ".ret"}, retire_cnt, 32'(m_ret));
        chk({e.nm, ".tk"}, taken_cnt, 32'(m_tk));
`else
        chk({e.nm, ".ret"}, retire_cnt, 32'd0);
        chk({e.nm, ".tk"}, taken_cnt, 32'd0);
`endif
    endtask

    initial begin
        nRST = 1'b0;
        cuOP = CU_ALU; rs1Read = '0; imm_i = '0;
        {cmp_eq, cmp_lt, cmp_ltu} = 3'b000;
        {iready, trap_i, trap_ack} = 3'b000;

        tbl.push_back(mk("boot", CU_ALU, 0, 0, 3'b000, 3'b100, 32'h0, 1, 0, 0, 0));
        tbl.push_back(mk("seq4", CU_ALU, 0, 0, 3'b000, 3'b100, 32'h4, 1, 0, 1, 0));
        tbl.push_back(mk("seq8", CU_ALU, 0, 0, 3'b000, 3'b100, 32'h8, 1, 0, 1, 0));
        tbl.push_back(mk("seqc", CU_ALU, 0, 0, 3'b000, 3'b100, 32'hc, 1, 0, 1, 0));
        tbl.push_back(mk("jal40", CU_JAL, 0, 32'h34, 3'b000, 3'b100, 32'h40, 1, 0, 1, 1));
        tbl.push_back(mk("beq_t", CU_BEQ, 0, 32'h10, 3'b100, 3'b100, 32'h50, 1, 0, 1, 1));
        tbl.push_back(mk("beq_n", CU_BEQ, 0, 32'h10, 3'b011, 3'b100, 32'h54, 1, 0, 1, 0));
        tbl.push_back(mk("bgeu_t", CU_BGEU, 0, 32'h10, 3'b010, 3'b100, 32'h64, 1, 0, 1, 1));
        tbl.push_back(mk("blt_t", CU_BLT, 0, 32'hffff_fff8, 3'b010, 3'b100, 32'h5c, 1, 0, 1, 1));
        tbl.push_back(mk("bge_n", CU_BGE, 0, 32'h10, 3'b010, 3'b100, 32'h60, 1, 0, 1, 0));
        tbl.push_back(mk("bltu_n", CU_BLTU, 0, 32'h10, 3'b110, 3'b100, 32'h64, 1, 0, 1, 0));
        tbl.push_back(mk("bne_n", CU_BNE, 0, 32'h20, 3'b100, 3'b100, 32'h68, 1, 0, 1, 0));
        tbl.push_back(mk("jalr", CU_JALR, 32'h1001, 32'h4, 3'b000, 3'b100, 32'h1004, 1, 0, 1, 1));
        tbl.push_back(mk("stall", CU_JAL, 0, 32'h8, 3'b000, 3'b000, 32'h1004, 1, 0, 0, 0));
        tbl.push_back(mk("jalr80", CU_JALR, 32'h80, 32'h0, 3'b000, 3'b100, 32'h80, 1, 0, 1, 1));

        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc", PCaddr, 32'h0);
        chk("rst.fr", 32'(fetch_req), 32'd0);
        chk("rst.trap", 32'(trap_o), 32'd0);
        chk("rst.epc", epc_o, 32'h0);
        chk("rst.cause", 32'(cause_o), 32'd0);
        chk("rst.ret", retire_cnt, 32'd0);
        nRST = 1'b1;
        chk("boot.fr", 32'(fetch_req), 32'd0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // misaligned JAL target 0x86
        apply(mk("mis", CU_JAL, 0, 32'h6, 3'b000, 3'b100, 32'h100, 0, 1, 0, 1));
        chk("mis.epc", epc_o, 32'h80);
        chk("mis.cause", 32'(cause_o), 32'd1);
        apply(mk("trhold", CU_JAL, 0, 32'h6, 3'b000, 3'b110, 32'h100, 0, 0, 0, 0));
        chk("trhold.cause", 32'(cause_o), 32'd1);
        apply(mk("ack", CU_ALU, 0, 0, 3'b000, 3'b001, 32'h100, 1, 0, 0, 0));
        chk("ack.epc", epc_o, 32'h80);

        // external trap beats a taken BNE at 0x20
        apply(mk("jal20", CU_JAL, 0, 32'hffff_ff20, 3'b000, 3'b100, 32'h20, 1, 0, 1, 1));
        apply(mk("ext", CU_BNE, 0, 32'h10, 3'b000, 3'b110, 32'h100, 0, 1, 0, 1));
        chk("ext.epc", epc_o, 32'h20);
        chk("ext.cause", 32'(cause_o), 32'd2);
        apply(mk("ack2", CU_ALU, 0, 0, 3'b000, 3'b001, 32'h100, 1, 0, 0, 0));

        // wrap through 2^32
        apply(mk("jalrfc", CU_JALR, 32'hffff_fff8, 32'h4, 3'b000, 3'b100, 32'hffff_fffc, 1, 0, 1, 1));
        apply(mk("wrap", CU_ALU, 0, 0, 3'b000, 3'b100, 32'h0, 1, 0, 1, 0));

        // external trap while stalled, then reset inside TRAP
        apply(mk("ext_st", CU_ALU, 0, 0, 3'b000, 3'b010, 32'h100, 0, 1, 0, 0));
        chk("ext_st.epc", epc_o, 32'h0);
        chk("ext_st.cause", 32'(cause_o), 32'd2);
        nRST = 1'b0;
        #1;
        chk("rst2.pc", PCaddr, 32'h0);
        chk("rst2.fr", 32'(fetch_req), 32'd0);
        chk("rst2.cause", 32'(cause_o), 32'd0);
        chk("rst2.epc", epc_o, 32'h0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        m_ret = 0;
        m_tk = 0;
        apply(mk("boot2", CU_ALU, 0, 0, 3'b000, 3'b100, 32'h0, 1, 0, 0, 0));
        apply(mk("run2", CU_ALU, 0, 0, 3'b000, 3'b100, 32'h4, 1, 0, 1, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
